// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 stage types and constants
// Used by the init, key-scheduling and PRGA stages.
package arc4_pkg;

  localparam logic [7:0]  LEN_ADDR  = 8'd0;
  localparam int unsigned SBOX_SIZE = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_LEN,
    ST_WT_LEN,
    ST_WR_LEN,
    ST_RD_SI,
    ST_WT_SI,
    ST_RD_SJ,
    ST_WT_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_PAD,
    ST_WT_PAD,
    ST_WR_PT
  } prga_state_e;

  function automatic logic [7:0] idx_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/prga_if.sv
// rtl/prga_if.sv - PRGA control, S-array, ciphertext and plaintext memory ports
// The slave modport is the PRGA side; master is the memory/host side.
interface prga_if;

  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

endinterface

// File: rtl/prga.sv
// rtl/prga.sv - ARC4 pseudo-random generation and decrypt stage
// Walks ct[1..n], swaps S entries and writes pad XOR ct into pt; pt[0] gets n.
module prga
  import arc4_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  prga_if.slave  bus
);

  localparam int IDX_W = $clog2(SBOX_SIZE);

  prga_state_e    state_q;
  logic [7:0]     i_q, j_q, si_q, sj_q, n_q;
  logic [IDX_W:0] k_q;
  logic           rdy_q, s_wren_q, pt_wren_q;
  logic [7:0]     s_addr_q, s_wrdata_q, ct_addr_q, pt_addr_q, pt_wrdata_q;

  logic [7:0]     i_d, j_d;
  logic           last_byte;

  always_comb begin
    i_d       = idx_add(i_q, 8'd1);
    j_d       = idx_add(j_q, bus.s_rddata);
    // k is one bit wider than n so that n=255 still terminates.
    last_byte = !(k_q < {1'b0, n_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b1;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
    end else begin
      // Outputs belong to the state being entered; anything not set here idles at 0.
      rdy_q       <= 1'b0;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.en) begin
            state_q   <= ST_RD_LEN;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= {{IDX_W{1'b0}}, 1'b1};
            ct_addr_q <= LEN_ADDR;
          end else begin
            rdy_q     <= 1'b1;
          end
        end
        ST_RD_LEN: state_q <= ST_WT_LEN;
        ST_WT_LEN: begin
          state_q     <= ST_WR_LEN;
          n_q         <= bus.ct_rddata;
          pt_addr_q   <= LEN_ADDR;
          pt_wrdata_q <= bus.ct_rddata;
          pt_wren_q   <= 1'b1;
        end
        ST_WR_LEN: begin
          if (n_q == 8'd0) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b1;
          end else begin
            state_q  <= ST_RD_SI;
            i_q      <= i_d;
            s_addr_q <= i_d;
          end
        end
        ST_RD_SI: state_q <= ST_WT_SI;
        ST_WT_SI: begin
          state_q  <= ST_RD_SJ;
          si_q     <= bus.s_rddata;
          j_q      <= j_d;
          s_addr_q <= j_d;
        end
        ST_RD_SJ: state_q <= ST_WT_SJ;
        ST_WT_SJ: begin
          state_q    <= ST_WR_SI;
          sj_q       <= bus.s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= bus.s_rddata;
          s_wren_q   <= 1'b1;
        end
        ST_WR_SI: begin
          state_q    <= ST_WR_SJ;
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
        end
        ST_WR_SJ: begin
          state_q   <= ST_RD_PAD;
          s_addr_q  <= idx_add(si_q, sj_q);
          ct_addr_q <= k_q[IDX_W-1:0];
        end
        ST_RD_PAD: state_q <= ST_WT_PAD;
        ST_WT_PAD: begin
          state_q     <= ST_WR_PT;
          pt_addr_q   <= k_q[IDX_W-1:0];
          pt_wrdata_q <= bus.s_rddata ^ bus.ct_rddata;
          pt_wren_q   <= 1'b1;
        end
        ST_WR_PT: begin
          if (last_byte) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b1;
          end else begin
            state_q  <= ST_RD_SI;
            k_q      <= k_q + 1'b1;
            i_q      <= i_d;
            s_addr_q <= i_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wrdata  = s_wrdata_q;
  assign bus.s_wren    = s_wren_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.pt_wrdata = pt_wrdata_q;
  assign bus.pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_prga.sv
// tb/tb_prga.sv - self-checking bench for prga against a software ARC4 model
module tb_prga;

  typedef struct packed {
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_wd;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] pt_addr;
    logic [7:0] pt_wd;
    logic       pt_wren;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   nprint = 0;
  int   busy = 0;

  always #5 clk = ~clk;

  prga_if bus();
  prga dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] s_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] s_rd, ct_rd;
  int         s_wr_cnt = 0;
  int         pt_wr_cnt = 0;
  logic [7:0] last_pt_addr = 8'h00;

  assign bus.s_rddata  = s_rd;
  assign bus.ct_rddata = ct_rd;

  always @(posedge clk) begin
    s_rd  <= s_mem[bus.s_addr];
    ct_rd <= ct_mem[bus.ct_addr];
    if (bus.s_wren === 1'b1) begin
      s_mem[bus.s_addr] = bus.s_wrdata;
      s_wr_cnt = s_wr_cnt + 1;
    end
    if (bus.pt_wren === 1'b1) begin
      pt_mem[bus.pt_addr] = bus.pt_wrdata;
      pt_wr_cnt = pt_wr_cnt + 1;
      last_pt_addr = bus.pt_addr;
    end
  end

  logic [7:0] m_s [256];
  logic [7:0] m_ct [256];
  logic [7:0] m_pt [256];
  out_t       exp_q [$];

  function automatic out_t mk(input logic r, input logic [7:0] sa, input logic [7:0] sw,
                              input logic swe, input logic [7:0] ca, input logic [7:0] pa,
                              input logic [7:0] pw, input logic pwe);
    out_t o;
    o.rdy = r; o.s_addr = sa; o.s_wd = sw; o.s_wren = swe;
    o.ct_addr = ca; o.pt_addr = pa; o.pt_wd = pw; o.pt_wren = pwe;
    return o;
  endfunction

  // Software ARC4 on m_s/m_ct, emitting the port values expected in each busy cycle.
  task automatic model_run();
    logic [7:0] n, i, j, si, sj, t, pad, pw;
    n = m_ct[0];
    i = 8'd0;
    j = 8'd0;
    exp_q.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0));
    exp_q.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0));
    exp_q.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, n, 1'b1));
    m_pt[0] = n;
    for (int k = 1; k <= int'(n); k++) begin
      i = i + 8'd1;
      si = m_s[i];
      j = j + si;
      sj = m_s[j];
      m_s[i] = sj;
      m_s[j] = si;
      t = si + sj;
      pad = m_s[t];
      pw = pad ^ m_ct[k];
      m_pt[k] = pw;
      exp_q.push_back(mk(1'b0, i, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0));
      exp_q.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0));
      exp_q.push_back(mk(1'b0, j, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0));
      exp_q.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0));
      exp_q.push_back(mk(1'b0, i, sj, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0));
      exp_q.push_back(mk(1'b0, j, si, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0));
      exp_q.push_back(mk(1'b0, t, 8'd0, 1'b0, 8'(k), 8'd0, 8'd0, 1'b0));
      exp_q.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0));
      exp_q.push_back(mk(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'(k), pw, 1'b1));
    end
    exp_q.push_back(mk(1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e, a;
      e = exp_q.pop_front();
      a = {bus.rdy, bus.s_addr, bus.s_wrdata, bus.s_wren,
           bus.ct_addr, bus.pt_addr, bus.pt_wrdata, bus.pt_wren};
      tests++;
      if (a !== e) begin
        fails++;
        if (nprint < 20)
          $display("FAIL trace t=%0t got rdy=%b s=%h/%h/%b ct=%h pt=%h/%h/%b expected rdy=%b s=%h/%h/%b ct=%h pt=%h/%h/%b",
                   $time, a.rdy, a.s_addr, a.s_wd, a.s_wren, a.ct_addr, a.pt_addr, a.pt_wd, a.pt_wren,
                   e.rdy, e.s_addr, e.s_wd, e.s_wren, e.ct_addr, e.pt_addr, e.pt_wd, e.pt_wren);
        nprint++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_q(input int target);
    int g;
    g = 0;
    while (exp_q.size() > target && g < 5000) begin
      @(negedge clk);
      #1;
      g++;
      if (bus.rdy !== 1'b1) busy++;
    end
    if (exp_q.size() > target) begin
      tests++;
      fails++;
      $display("FAIL wait_q: timeout with %0d entries left, expected at most %0d", exp_q.size(), target);
      exp_q.delete();
    end
  endtask

  task automatic launch(input int runs);
    @(negedge clk);
    #1;
    for (int r = 0; r < runs; r++) model_run();
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    if (runs == 1) bus.en = 1'b0;
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) m_s[a] = 8'(a);
  endtask

  task automatic ksa();
    logic [7:0] key [3];
    logic [7:0] j, t;
    key[0] = 8'h00; key[1] = 8'h03; key[2] = 8'h3C;
    set_identity();
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + m_s[a] + key[a % 3];
      t = m_s[a];
      m_s[a] = m_s[j];
      m_s[j] = t;
    end
  endtask

  task automatic load_mems();
    for (int a = 0; a < 256; a++) begin
      s_mem[a]  = m_s[a];
      ct_mem[a] = m_ct[a];
      pt_mem[a] = 8'hEE;
    end
  endtask

  task automatic chk_pt(input string nm);
    int bad;
    bad = 0;
    for (int a = 0; a <= int'(m_ct[0]); a++) if (pt_mem[a] !== m_pt[a]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic chk_s(input string nm);
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) bad++;
    chk(nm, bad, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps, pw;
    bus.en = 1'b0;
    rst = 1'b1;
    for (int a = 0; a < 256; a++) begin m_s[a] = 8'(a); m_ct[a] = 8'd0; m_pt[a] = 8'd0; end
    load_mems();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", bus.rdy, 1);
    chk("reset_outs", |{bus.s_addr, bus.s_wrdata, bus.s_wren, bus.ct_addr,
                        bus.pt_addr, bus.pt_wrdata, bus.pt_wren}, 0);
    #1 bus.en = 1'b1;
    @(negedge clk);
    chk("rst_over_en", bus.rdy, 1);
    #1 rst = 1'b0;
    bus.en = 1'b0;

    // n = 0
    set_identity();
    for (int a = 0; a < 256; a++) m_ct[a] = 8'(a * 7);
    m_ct[0] = 8'd0;
    load_mems();
    ps = s_wr_cnt; pw = pt_wr_cnt; busy = 0;
    launch(1);
    wait_q(0);
    chk("n0_busy", busy, 3);
    chk("n0_pt_writes", pt_wr_cnt - pw, 1);
    chk("n0_s_writes", s_wr_cnt - ps, 0);
    chk("n0_pt0", pt_mem[0], 8'h00);

    // identity S, hand-computed result
    set_identity();
    m_ct[0] = 8'd2; m_ct[1] = 8'h41; m_ct[2] = 8'h00;
    load_mems();
    busy = 0;
    launch(1);
    wait_q(0);
    chk("id_busy", busy, 21);
    chk("id_pt0", pt_mem[0], 8'h02);
    chk("id_pt1", pt_mem[1], 8'h43);
    chk("id_pt2", pt_mem[2], 8'h05);
    chk("id_s2", s_mem[2], 8'h03);
    chk("id_s3", s_mem[3], 8'h02);

    // golden vector from KSA of key 00 03 3C
    ksa();
    m_ct[0] = 8'd32;
    for (int k = 1; k <= 32; k++) m_ct[k] = 8'(k * 29 + 3);
    load_mems();
    busy = 0;
    launch(1);
    wait_q(0);
    chk("gold_busy", busy, 3 + 9 * 32);
    chk_pt("gold_pt");
    chk_s("gold_s");

    // n = 255
    ksa();
    m_ct[0] = 8'd255;
    for (int k = 1; k < 256; k++) m_ct[k] = 8'(k) ^ 8'h5A;
    load_mems();
    busy = 0; pw = pt_wr_cnt;
    launch(1);
    wait_q(0);
    chk("n255_busy", busy, 2298);
    chk("n255_pt_writes", pt_wr_cnt - pw, 256);
    chk("n255_last_pt", last_pt_addr, 8'd255);
    chk_pt("n255_pt");
    chk_s("n255_s");

    // en held through a run, then back-to-back restart
    set_identity();
    m_ct[0] = 8'd5;
    for (int k = 1; k <= 5; k++) m_ct[k] = 8'(k * 17);
    load_mems();
    pw = pt_wr_cnt;
    launch(2);
    wait_q(3 + 9 * 5);
    bus.en = 1'b0;
    wait_q(0);
    chk("busy_pt_writes", pt_wr_cnt - pw, 12);
    chk_pt("busy_pt");
    chk_s("busy_s");

    // reset during WR_SI of byte 3
    set_identity();
    m_ct[0] = 8'd4; m_ct[1] = 8'h10; m_ct[2] = 8'h20; m_ct[3] = 8'h30; m_ct[4] = 8'h40;
    load_mems();
    launch(1);
    exp_q = exp_q[0:25];
    wait_q(0);
    chk("mid_at_wr_si", bus.s_wren, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rdy", bus.rdy, 1);
    chk("mid_wrens", {bus.s_wren, bus.pt_wren}, 0);
    ps = s_wr_cnt; pw = pt_wr_cnt;
    repeat (5) @(negedge clk);
    chk("mid_no_writes", (s_wr_cnt - ps) + (pt_wr_cnt - pw), 0);
    set_identity();
    load_mems();
    launch(1);
    wait_q(0);
    chk_pt("mid_rerun_pt");
    chk_s("mid_rerun_s");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
